// File: rtl/lattuino_spm_pkg.sv
// Shared opcode and state definitions for the Lattuino program memory
// with page-buffered self-programming.
package lattuino_spm_pkg;

    localparam logic [1:0] SPM_FILL  = 2'b00;
    localparam logic [1:0] SPM_ERASE = 2'b01;
    localparam logic [1:0] SPM_WRITE = 2'b10;
    localparam logic [1:0] SPM_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ERASE = 2'b01,
        ST_WRITE = 2'b10
    } spm_state_t;

endpackage

// File: rtl/lattuino_bram_sp.sv
// Block RAM with a registered read address (captured while ren_i is high),
// one synchronous write port and optional falling-edge clocking.
module lattuino_bram_sp #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_W    = 13,
    parameter int FALL_EDGE = 0,
    parameter     INIT_FILE = ""
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ren_i,
    input  logic [ADDR_W-1:0]    raddr_i,
    output logic [WORD_SIZE-1:0] data_o,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    waddr_i,
    input  logic [WORD_SIZE-1:0] wdata_i
);

    logic                 clk_int;
    logic [ADDR_W-1:0]    addr_q;
    logic [WORD_SIZE-1:0] mem_q [0:(2**ADDR_W)-1];

    assign clk_int = (FALL_EDGE != 0) ? ~clk_i : clk_i;

    always_ff @(posedge clk_int or posedge rst_i) begin
        if (rst_i)      addr_q <= '0;
        else if (ren_i) addr_q <= raddr_i;
    end

    always_ff @(posedge clk_int) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read is combinational from the registered address, so a write to the
    // held address shows up on data_o right after the writing edge.
    assign data_o = mem_q[addr_q];

endmodule

// File: rtl/lattuino_pm_spm.sv
// AVR program memory with a page buffer and an erase/write sequencer that
// programs one word per cycle while the fetch address is held.
module lattuino_pm_spm
    import lattuino_spm_pkg::*;
#(
    parameter int                   WORD_SIZE = 16,
    parameter int                   ADDR_W    = 13,
    parameter int                   PAGE_W    = 6,
    parameter int                   FALL_EDGE = 0,
    parameter                       INIT_FILE = "",
    parameter logic [WORD_SIZE-1:0] ERASE_VAL = '1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_W-1:0]    addr_i,
    output logic [WORD_SIZE-1:0] data_o,
    input  logic                 spm_we_i,
    input  logic [1:0]           spm_op_i,
    input  logic [ADDR_W-1:0]    spm_addr_i,
    input  logic [WORD_SIZE-1:0] spm_data_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int PAGE_WORDS = 2**PAGE_W;
    localparam int PNUM_W     = ADDR_W - PAGE_W;

    logic                  clk_int;
    spm_state_t            state_q, state_d;
    logic [PAGE_W-1:0]     cnt_q, cnt_d;
    logic [PNUM_W-1:0]     page_q, page_d;
    logic                  prime_q, prime_d;
    logic [PAGE_WORDS-1:0] valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  bvld_q;

    logic                  buf_we;
    logic [PAGE_W-1:0]     buf_raddr;
    logic [WORD_SIZE-1:0]  buf_dout;
    logic                  mem_we;
    logic [WORD_SIZE-1:0]  mem_wdata;

    assign clk_int = (FALL_EDGE != 0) ? ~clk_i : clk_i;
    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = done_q;
    assign err_o   = err_q;

    assign buf_we    = (state_q == ST_IDLE) && spm_we_i && (spm_op_i == SPM_FILL);
    // The buffer read runs one slot ahead of the word being written.
    assign buf_raddr = prime_q ? '0 : cnt_q + 1'b1;

    assign mem_we    = (state_q == ST_ERASE) || ((state_q == ST_WRITE) && !prime_q);
    assign mem_wdata = ((state_q == ST_WRITE) && bvld_q) ? buf_dout : ERASE_VAL;

    lattuino_bram_sp #(
        .WORD_SIZE (WORD_SIZE),
        .ADDR_W    (ADDR_W),
        .FALL_EDGE (FALL_EDGE),
        .INIT_FILE (INIT_FILE)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .ren_i   (!busy_o),
        .raddr_i (addr_i),
        .data_o  (data_o),
        .we_i    (mem_we),
        .waddr_i ({page_q, cnt_q}),
        .wdata_i (mem_wdata)
    );

    lattuino_bram_sp #(
        .WORD_SIZE (WORD_SIZE),
        .ADDR_W    (PAGE_W),
        .FALL_EDGE (FALL_EDGE),
        .INIT_FILE ("")
    ) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .ren_i   (1'b1),
        .raddr_i (buf_raddr),
        .data_o  (buf_dout),
        .we_i    (buf_we),
        .waddr_i (spm_addr_i[PAGE_W-1:0]),
        .wdata_i (spm_data_i)
    );

    always_ff @(posedge clk_int or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            page_q  <= '0;
            prime_q <= 1'b0;
            valid_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            page_q  <= page_d;
            prime_q <= prime_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            bvld_q  <= valid_q[buf_raddr];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        page_d  = page_q;
        prime_d = prime_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (spm_we_i) begin
                    case (spm_op_i)
                        SPM_FILL:  valid_d[spm_addr_i[PAGE_W-1:0]] = 1'b1;
                        SPM_CLEAR: valid_d = '0;
                        SPM_ERASE: begin
                            page_d  = spm_addr_i[ADDR_W-1:PAGE_W];
                            cnt_d   = '0;
                            state_d = ST_ERASE;
                        end
                        default: begin
                            page_d  = spm_addr_i[ADDR_W-1:PAGE_W];
                            cnt_d   = '0;
                            prime_d = 1'b1;
                            state_d = ST_WRITE;
                        end
                    endcase
                end
            end
            ST_ERASE: begin
                err_d = spm_we_i;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_WRITE: begin
                err_d = spm_we_i;
                if (prime_q) begin
                    prime_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        valid_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
